// File: rtl/game_pkg.sv
// Shared definitions for the game screen path: screen geometry, colour constants
// and the widths of the game_if timing bundle.
package game_pkg;
  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;
  localparam int RGB_W    = 12;
  localparam int TIMING_W = HCOUNT_W + VCOUNT_W + 4;

  localparam logic [RGB_W-1:0] RGB_BG_DEFAULT = 12'h000;
  localparam logic [RGB_W-1:0] RGB_TRANSP_KEY = 12'hF0F;

  // Timing bundle as it travels through the retiming pipeline.
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
  } timing_t;
endpackage

// File: rtl/game_if.sv
// Video timing + pixel colour bundle passed between screen layers.
//  in  modport : consumer side (all signals are inputs)
//  out modport : producer side (all signals are outputs)
interface game_if;
  import game_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                hblnk;
  logic                vblnk;
  logic [RGB_W-1:0]    rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/signal_delay.sv
// Fixed-length shift register used to retime side signals to the ROM latency.
//  clk    in  1      clock
//  rst_n  in  1      asynchronous active-low reset, clears every stage to 0
//  din    in  WIDTH  value entering the delay line
//  dout   out WIDTH  din delayed by CLK_DEL cycles (CLK_DEL >= 1)
module signal_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] sr_q [CLK_DEL];
  logic [WIDTH-1:0] sr_d [CLK_DEL];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[CLK_DEL-1];
endmodule

// File: rtl/image_screen.sv
// Image layer: places a (possibly upscaled, possibly animated) ROM image at
// (X0,Y0), drives the ROM address, composites the ROM pixel over a background
// and retimes the game_if timing to the ROM latency (total latency ROM_LATENCY+2).
//  clk, rst_n   clock, asynchronous active-low reset
//  anim_en      1: animation frame counter advances on vsync rising edges
//  restart      1-cycle pulse: frame and hold counters back to 0
//  rgb_pixel    ROM data, ROM_LATENCY cycles after pixel_addr
//  in / out     timing + rgb from previous layer / retimed composited output
//  pixel_addr   registered ROM address
//  frame_idx    current animation frame
module image_screen
  import game_pkg::*;
#(
  parameter int               IMG_W       = 1024,
  parameter int               IMG_H       = 768,
  parameter int               X0          = 0,
  parameter int               Y0          = 0,
  parameter int               SCALE_LOG2  = 0,
  parameter int               NUM_FRAMES  = 1,
  parameter int               FRAME_HOLD  = 8,
  parameter int               ROM_LATENCY = 1,
  parameter int               ADDR_W      = 20,
  parameter int               BG_MODE     = 0,
  parameter logic [RGB_W-1:0] BG_RGB      = RGB_BG_DEFAULT,
  parameter int               TRANSP_EN   = 0,
  parameter logic [RGB_W-1:0] TRANSP_RGB  = RGB_TRANSP_KEY,
  localparam int              FRAME_W     = $clog2(NUM_FRAMES) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               anim_en,
  input  logic               restart,
  input  logic [RGB_W-1:0]   rgb_pixel,
  game_if.in                 in,
  game_if.out                out,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic [FRAME_W-1:0] frame_idx
);
  localparam int HOLD_W = $clog2(FRAME_HOLD) + 1;
  localparam int X_END  = X0 + (IMG_W << SCALE_LOG2);
  localparam int Y_END  = Y0 + (IMG_H << SCALE_LOG2);

  localparam logic [31:0]         FRAME_SZ   = 32'(IMG_W * IMG_H);
  localparam logic [31:0]         IMG_W32    = 32'(IMG_W);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  if (64'(NUM_FRAMES) * 64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_W)) begin : g_addr_w_check
    $error("image_screen: ADDR_W too narrow for NUM_FRAMES*IMG_W*IMG_H");
  end

  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic               inside_d, inside_q;
  logic [FRAME_W-1:0] frame_d, frame_q;
  logic [HOLD_W-1:0]  hold_d, hold_q;
  logic               vsync_q;
  logic               vs_edge;
  timing_t            tim_in, tim_dly, tim_q;
  logic [RGB_W-1:0]   bg_in_dly, bg, rgb_d, rgb_q;
  logic               inside_dly;
  logic [TIMING_W+RGB_W-1:0] bundle_dly;
  int                 hc_i, vc_i;
  logic [31:0]        rel_x, rel_y;

  // S0: window test and ROM address. Compare before subtracting so that
  // positions left of / above the image never underflow into a valid address.
  always_comb begin
    hc_i     = 32'(in.hcount);
    vc_i     = 32'(in.vcount);
    inside_d = (hc_i >= X0) && (hc_i < X_END) && (vc_i >= Y0) && (vc_i < Y_END);
    rel_x    = 32'(hc_i - X0) >> SCALE_LOG2;
    rel_y    = 32'(vc_i - Y0) >> SCALE_LOG2;
    addr_d   = '0;
    if (inside_d) begin
      addr_d = ADDR_W'(32'(frame_q) * FRAME_SZ + rel_y * IMG_W32 + rel_x);
    end
  end

  // Animation counters; only a vsync rising edge can move the frame, so the
  // image never changes mid-frame. restart wins over a simultaneous edge.
  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    vs_edge = in.vsync & ~vsync_q;
    if (restart) begin
      hold_d  = '0;
      frame_d = '0;
    end else if (vs_edge && anim_en) begin
      if (hold_q == HOLD_LAST) begin
        hold_d  = '0;
        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  assign tim_in = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk};

  // S1..S(ROM_LATENCY+1): timing and background arrive together with rgb_pixel.
  signal_delay #(.WIDTH(TIMING_W + RGB_W), .CLK_DEL(ROM_LATENCY + 1)) u_timing_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({tim_in, in.rgb}),
    .dout (bundle_dly)
  );

  // inside_q is already one stage in, so it needs ROM_LATENCY more.
  signal_delay #(.WIDTH(1), .CLK_DEL(ROM_LATENCY)) u_inside_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (inside_q),
    .dout (inside_dly)
  );

  assign tim_dly   = bundle_dly[TIMING_W+RGB_W-1:RGB_W];
  assign bg_in_dly = bundle_dly[RGB_W-1:0];

  // Output stage: blanking forces black, otherwise image over background.
  always_comb begin
    bg = (BG_MODE != 0) ? bg_in_dly : BG_RGB;
    if (tim_dly.hblnk | tim_dly.vblnk) begin
      rgb_d = '0;
    end else if (!inside_dly) begin
      rgb_d = bg;
    end else if ((TRANSP_EN != 0) && (rgb_pixel == TRANSP_RGB)) begin
      rgb_d = bg;
    end else begin
      rgb_d = rgb_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      inside_q <= 1'b0;
      frame_q  <= '0;
      hold_q   <= '0;
      vsync_q  <= 1'b0;
      tim_q    <= '0;
      rgb_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      inside_q <= inside_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      vsync_q  <= in.vsync;
      tim_q    <= tim_dly;
      rgb_q    <= rgb_d;
    end
  end

  assign out.hcount = tim_q.hcount;
  assign out.vcount = tim_q.vcount;
  assign out.hsync  = tim_q.hsync;
  assign out.vsync  = tim_q.vsync;
  assign out.hblnk  = tim_q.hblnk;
  assign out.vblnk  = tim_q.vblnk;
  assign out.rgb    = rgb_q;
  assign pixel_addr = addr_q;
  assign frame_idx  = frame_q;
endmodule

// File: tb/tb_image_screen.sv
module tb_image_screen;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        anim_en = 1'b0;
  logic        restart = 1'b0;
  logic [11:0] rgb_pix_a = '0;
  logic [11:0] rgb_pix_b = '0;
  logic [19:0] addr_a, addr_b;
  logic [2:0]  frame_a, frame_b;

  game_if in_if ();
  game_if out_a ();
  game_if out_b ();

  // A: solid background, no transparency. B: overlay background with colour key.
  image_screen #(
    .IMG_W(8), .IMG_H(4), .X0(100), .Y0(50), .SCALE_LOG2(1), .NUM_FRAMES(3),
    .FRAME_HOLD(2), .ROM_LATENCY(1), .ADDR_W(20), .BG_MODE(0), .BG_RGB(12'h0A5),
    .TRANSP_EN(0), .TRANSP_RGB(12'hF0F)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .anim_en(anim_en), .restart(restart),
    .rgb_pixel(rgb_pix_a), .in(in_if), .out(out_a),
    .pixel_addr(addr_a), .frame_idx(frame_a)
  );

  image_screen #(
    .IMG_W(8), .IMG_H(4), .X0(100), .Y0(50), .SCALE_LOG2(1), .NUM_FRAMES(3),
    .FRAME_HOLD(2), .ROM_LATENCY(1), .ADDR_W(20), .BG_MODE(1), .BG_RGB(12'h000),
    .TRANSP_EN(1), .TRANSP_RGB(12'hF0F)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .anim_en(anim_en), .restart(restart),
    .rgb_pixel(rgb_pix_b), .in(in_if), .out(out_b),
    .pixel_addr(addr_b), .frame_idx(frame_b)
  );

  always #5 clk = ~clk;

  // ROM models, one cycle latency.
  logic [11:0] rom [96];
  always @(posedge clk) begin
    rgb_pix_a <= (addr_a < 20'd96) ? rom[addr_a[6:0]] : 12'h000;
    rgb_pix_b <= (addr_b < 20'd96) ? rom[addr_b[6:0]] : 12'h000;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int   m_frame = 0;
  int   m_hold = 0;
  logic m_vs_prev = 1'b0;
  logic m_anim = 1'b0;

  // Scoreboard pop: output due LAT=3 cycles after the inputs were captured.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if ({out_a.hcount, out_a.vcount, out_a.hsync, out_a.vsync, out_a.hblnk, out_a.vblnk,
           out_b.hcount, out_b.vcount, out_b.hsync, out_b.vsync, out_b.hblnk, out_b.vblnk} !==
          {mon_e.hc, mon_e.vc, mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb,
           mon_e.hc, mon_e.vc, mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb}) begin
        errors++;
        $display("FAIL timing cyc=%0d got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b exp hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b",
                 cyc, out_a.hcount, out_a.vcount, out_a.hsync, out_a.vsync, out_a.hblnk, out_a.vblnk,
                 mon_e.hc, mon_e.vc, mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb);
      end
      checks++;
      if (out_a.rgb !== mon_e.rgb_a) begin
        errors++;
        $display("FAIL rgb_a cyc=%0d got=%h exp=%h", cyc, out_a.rgb, mon_e.rgb_a);
      end
      checks++;
      if (out_b.rgb !== mon_e.rgb_b) begin
        errors++;
        $display("FAIL rgb_b cyc=%0d got=%h exp=%h", cyc, out_b.rgb, mon_e.rgb_b);
      end
    end
  end

  // Drive one cycle of inputs and push the expected output.
  task automatic drive(input int hc, input int vc, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb, input logic rs);
    exp_t        e;
    logic        ins;
    int          addr;
    logic [11:0] pix;
    @(posedge clk);
    #1;
    in_if.hcount = 11'(hc);
    in_if.vcount = 11'(vc);
    in_if.hsync  = hs;
    in_if.vsync  = vs;
    in_if.hblnk  = hb;
    in_if.vblnk  = vb;
    in_if.rgb    = rgb;
    restart      = rs;
    anim_en      = m_anim;
    ins  = (hc >= 100) && (hc < 116) && (vc >= 50) && (vc < 58);
    addr = ins ? (m_frame * 32 + ((vc - 50) / 2) * 8 + (hc - 100) / 2) : 0;
    pix  = rom[addr];
    e.due = cyc + 3;
    e.hc = 11'(hc); e.vc = 11'(vc);
    e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    if (hb || vb) begin
      e.rgb_a = 12'h000; e.rgb_b = 12'h000;
    end else if (!ins) begin
      e.rgb_a = 12'h0A5; e.rgb_b = rgb;
    end else begin
      e.rgb_a = pix;
      e.rgb_b = (pix == 12'hF0F) ? rgb : pix;
    end
    sb.push_back(e);
    if (rs) begin
      m_frame = 0; m_hold = 0;
    end else if (vs && !m_vs_prev && m_anim) begin
      if (m_hold == 1) begin
        m_hold = 0;
        m_frame = (m_frame == 2) ? 0 : m_frame + 1;
      end else begin
        m_hold++;
      end
    end
    m_vs_prev = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse(input logic rs);
    drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, rs);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_a.hcount, out_a.vcount, out_a.hsync, out_a.vsync, out_a.hblnk, out_a.vblnk, out_a.rgb} !== 38'd0) begin
      errors++;
      $display("FAIL reset_out got rgb=%h hc=%0d exp all zero", out_a.rgb, out_a.hcount);
    end
    checks++;
    if (addr_a !== 20'd0 || frame_a !== 3'd0) begin
      errors++;
      $display("FAIL reset_addr_frame got addr=%0d frame=%0d exp 0 0", addr_a, frame_a);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_address();
    drive(100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0);
    drive(103, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0);
    checks++;
    if (addr_a !== 20'd0) begin errors++; $display("FAIL addr_100_50 got=%0d exp=0", addr_a); end
    drive(115, 57, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0);
    checks++;
    if (addr_a !== 20'd9) begin errors++; $display("FAIL addr_103_53 got=%0d exp=9", addr_a); end
    idle(1);
    checks++;
    if (addr_a !== 20'd31 || addr_b !== 20'd31) begin
      errors++; $display("FAIL addr_115_57 got=%0d/%0d exp=31", addr_a, addr_b);
    end
  endtask

  task automatic test_outside_blank();
    drive(116, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 1'b0);
    idle(1);
    checks++;
    if (addr_a !== 20'd0) begin errors++; $display("FAIL addr_116 got=%0d exp=0", addr_a); end
    drive(99, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h654, 1'b0);
    idle(1);
    checks++;
    if (addr_a !== 20'd0) begin errors++; $display("FAIL addr_99 got=%0d exp=0", addr_a); end
    drive(104, 51, 1'b0, 1'b0, 1'b1, 1'b0, 12'h777, 1'b0);
    drive(104, 51, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777, 1'b0);
    idle(4);
  endtask

  task automatic test_sync_rom();
    drive(103, 53, 1'b1, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0);
    drive(103, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0);
    idle(2);
    checks++;
    if (out_a.hsync !== 1'b1 || out_a.rgb !== 12'hABC) begin
      errors++; $display("FAIL hsync_rom_t3 got hs=%b rgb=%h exp hs=1 rgb=abc", out_a.hsync, out_a.rgb);
    end
    idle(3);
  endtask

  task automatic test_transparency();
    drive(104, 52, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0);
    drive(106, 52, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0);
    idle(2);
    checks++;
    if (out_b.rgb !== 12'h123) begin
      errors++; $display("FAIL transp_key got=%h exp=123", out_b.rgb);
    end
    idle(4);
  endtask

  task automatic test_anim();
    m_anim = 1'b1;
    vs_pulse(1'b0);
    vs_pulse(1'b0);
    idle(1);
    checks++;
    if (frame_a !== 3'd1) begin errors++; $display("FAIL frame_after_2 got=%0d exp=1", frame_a); end
    drive(100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    idle(1);
    checks++;
    if (addr_a !== 20'd32) begin errors++; $display("FAIL addr_frame1 got=%0d exp=32", addr_a); end
    repeat (4) vs_pulse(1'b0);
    idle(1);
    checks++;
    if (frame_a !== 3'd0) begin errors++; $display("FAIL frame_wrap got=%0d exp=0", frame_a); end
    vs_pulse(1'b0);
    vs_pulse(1'b1);
    idle(1);
    checks++;
    if (frame_a !== 3'd0) begin errors++; $display("FAIL restart_on_edge got=%0d exp=0", frame_a); end
    vs_pulse(1'b0);
    vs_pulse(1'b0);
    idle(1);
    checks++;
    if (frame_a !== 3'd1 || frame_b !== 3'd1) begin
      errors++; $display("FAIL frame_after_restart got=%0d/%0d exp=1", frame_a, frame_b);
    end
    m_anim = 1'b0;
    vs_pulse(1'b0);
    vs_pulse(1'b0);
    idle(1);
    checks++;
    if (frame_a !== 3'd1) begin errors++; $display("FAIL anim_hold got=%0d exp=1", frame_a); end
    idle(3);
  endtask

  task automatic test_reset_midframe();
    m_anim = 1'b1;
    repeat (3) vs_pulse(1'b0);
    idle(1);
    checks++;
    if (frame_a !== 3'd2) begin errors++; $display("FAIL frame_pre_reset got=%0d exp=2", frame_a); end
    drive(102, 54, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
    drive(104, 54, 1'b1, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
    drive(106, 54, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
    drive(108, 54, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_a.hcount, out_a.vcount, out_a.hsync, out_a.rgb, out_b.rgb} !== 47'd0 ||
        addr_a !== 20'd0 || frame_a !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got hc=%0d rgb=%h addr=%0d frame=%0d exp all zero",
               out_a.hcount, out_a.rgb, addr_a, frame_a);
    end
    m_frame = 0; m_hold = 0; m_vs_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vs_pulse(1'b0);
    idle(1);
    checks++;
    if (frame_a !== 3'd0) begin errors++; $display("FAIL hold_cleared got=%0d exp=0", frame_a); end
    drive(110, 56, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 1'b0);
    drive(99, 56, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 1'b0);
    idle(4);
  endtask

  task automatic test_back_to_back();
    m_anim = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(119, 96), $urandom_range(59, 48), ($urandom_range(7, 0) == 0),
            1'b0, ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0),
            12'($urandom_range(4095, 0)), 1'b0);
    end
    idle(5);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 96; i++) rom[i] = 12'(i * 37 + 5);
    rom[9]  = 12'hABC;
    rom[10] = 12'hF0F;
    rom[11] = 12'h0F0;
    in_if.hcount = '0; in_if.vcount = '0; in_if.hsync = 1'b0; in_if.vsync = 1'b0;
    in_if.hblnk = 1'b1; in_if.vblnk = 1'b1; in_if.rgb = '0;
    test_reset();
    test_address();
    test_outside_blank();
    test_sync_rom();
    test_transparency();
    test_anim();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
